// File: rtl/sr_driver_pkg.sv
// Shared types and constants for the SR latch driver.
// Holds the FSM state encoding, expected readback codes and a max helper.
package sr_driver_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP,
        CHECK
    } sr_state_t;

    // Expected {Q,Qbar} after a set / reset command
    localparam logic [1:0] SR_EXP_SET = 2'b10;
    localparam logic [1:0] SR_EXP_RST = 2'b01;

    function automatic int sr_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sr_latch_driver_if.sv
// Command handshake plus latch drive/readback bundle for sr_latch_driver.
// slave: the driver (accepts commands, drives S/R); master: requester side.
interface sr_latch_driver_if;

    logic req_valid;
    logic req_set;
    logic req_ready;
    logic S;
    logic R;
    logic Q;
    logic Qbar;
    logic done;
    logic err;
    logic state_q;
    logic state_known;

    modport slave (
        input  req_valid,
        input  req_set,
        input  Q,
        input  Qbar,
        output req_ready,
        output S,
        output R,
        output done,
        output err,
        output state_q,
        output state_known
    );

    modport master (
        output req_valid,
        output req_set,
        output Q,
        output Qbar,
        input  req_ready,
        input  S,
        input  R,
        input  done,
        input  err,
        input  state_q,
        input  state_known
    );

endinterface

// File: rtl/sr_readback_sync.sv
// Registers latch readback {Q,Qbar} before the driver compares it.
// Ports: clk, n_rst (async low), i_q, i_qbar -> o_rb = {Q,Qbar} delayed.
// SR_LATCH_DRIVER_SYNC_EN selects a two-flop synchronizer, else one flop.
module sr_readback_sync (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       i_q,
    input  logic       i_qbar,
    output logic [1:0] o_rb
);

`ifdef SR_LATCH_DRIVER_SYNC_EN
    logic [1:0] r_meta;
    logic [1:0] r_sync;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_meta <= 2'b00;
            r_sync <= 2'b00;
        end else begin
            r_meta <= {i_q, i_qbar};
            r_sync <= r_meta;
        end
    end

    assign o_rb = r_sync;
`else
    logic [1:0] r_rb;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rb <= 2'b00;
        end else begin
            r_rb <= {i_q, i_qbar};
        end
    end

    assign o_rb = r_rb;
`endif

endmodule

// File: rtl/sr_latch_driver.sv
// Drives S/R of an external SR latch from a valid/ready command and
// confirms the new state via Q/Qbar readback. Ports: clk, n_rst (async
// low), bus (slave modport: req_valid/req_set/req_ready, S, R, Q, Qbar,
// done, err, state_q, state_known). Option: SR_LATCH_DRIVER_SYNC_EN.
module sr_latch_driver
    import sr_driver_pkg::*;
#(
    parameter int PULSE_CYCLES   = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic               clk,
    input  logic               n_rst,
    sr_latch_driver_if.slave   bus
);

    localparam int CW =
        $clog2(sr_max3(PULSE_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES) + 1);

    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] TOUT_LD  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = '0;

    sr_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic          r_cmd;
    logic          r_s;
    logic          r_r;
    logic          r_ready;
    logic          r_done;
    logic          r_err;
    logic          r_state_q;
    logic          r_known;

    logic [1:0]    w_rb;
    logic [1:0]    w_exp;
    logic          w_match;
    logic          w_cnt_zero;

    sr_readback_sync u_sync (
        .clk    (clk),
        .n_rst  (n_rst),
        .i_q    (bus.Q),
        .i_qbar (bus.Qbar),
        .o_rb   (w_rb)
    );

    assign w_exp      = r_cmd ? SR_EXP_SET : SR_EXP_RST;
    // 00/11 never equal an expected code; X/Z never compare true
    assign w_match    = (w_rb == w_exp);
    assign w_cnt_zero = (r_cnt == CNT_ZERO);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= IDLE;
            r_cnt     <= CNT_ZERO;
            r_cmd     <= 1'b0;
            r_s       <= 1'b0;
            r_r       <= 1'b0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_state_q <= 1'b0;
            r_known   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_cmd   <= bus.req_set;
                        // S and R come from one bit, never both high
                        r_s     <= bus.req_set;
                        r_r     <= !bus.req_set;
                        r_cnt   <= PULSE_LD;
                        r_ready <= 1'b0;
                        r_state <= PULSE;
                    end
                end
                PULSE: begin
                    if (w_cnt_zero) begin
                        r_s     <= 1'b0;
                        r_r     <= 1'b0;
                        r_cnt   <= GAP_LD;
                        r_state <= GAP;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                GAP: begin
                    if (w_cnt_zero) begin
                        r_cnt   <= TOUT_LD;
                        r_state <= CHECK;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                CHECK: begin
                    if (w_match) begin
                        r_done    <= 1'b1;
                        r_state_q <= r_cmd;
                        r_known   <= 1'b1;
                        r_ready   <= 1'b1;
                        r_state   <= IDLE;
                    end else if (w_cnt_zero) begin
                        r_err   <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    r_s     <= 1'b0;
                    r_r     <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = r_ready;
    assign bus.S           = r_s;
    assign bus.R           = r_r;
    assign bus.done        = r_done;
    assign bus.err         = r_err;
    assign bus.state_q     = r_state_q;
    assign bus.state_known = r_known;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver with a behavioural srgate model.
// Expected done/err outcomes are queued per command and popped on response.
module tb_sr_latch_driver;

    localparam int P      = 4;
    localparam int G      = 2;
    localparam int T      = 8;
    localparam int LAT_OK = 2 + P + G;
    localparam int LAT_TO = 1 + P + G + T;
    localparam logic [31:0] PMASK = 32'(((1 << P) - 1) << 1);

    logic clk   = 1'b0;
    logic n_rst = 1'b0;

    always #5 clk = ~clk;

    sr_latch_driver_if bus ();

    sr_latch_driver #(
        .PULSE_CYCLES   (P),
        .GAP_CYCLES     (G),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    // Behavioural cross-coupled latch; stuck forces readback to 00
    logic lq    = 1'b0;
    logic stuck = 1'b0;

    always @(bus.S or bus.R) begin
        if (bus.S && !bus.R)
            lq = 1'b1;
        else if (bus.R && !bus.S)
            lq = 1'b0;
    end

    assign bus.Q    = stuck ? 1'b0 : lq;
    assign bus.Qbar = stuck ? 1'b0 : ~lq;

    typedef struct {
        bit is_err;
        bit q;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    bit model_q     = 1'b0;
    bit model_known = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command at the current negedge; accept at the next posedge
    task automatic run_cmd(input string tag, input bit set, input bit ok,
                           input bit hold, input bit next_set);
        exp_t e;
        logic [31:0] smask;
        logic [31:0] rmask;
        bit both;
        bit seen;
        int lat;
        bit o_err;
        bit o_rdy;
        bit o_q;
        bit o_kn;
        smask = '0;
        rmask = '0;
        both  = 1'b0;
        seen  = 1'b0;
        lat   = 0;
        o_err = 1'b0;
        o_rdy = 1'b0;
        o_q   = 1'b0;
        o_kn  = 1'b0;
        e.is_err = !ok;
        e.q      = ok ? set : model_q;
        sb.push_back(e);
        if (ok) begin
            model_q     = set;
            model_known = 1'b1;
        end
        bus.req_valid = 1'b1;
        bus.req_set   = set;
        for (int c = 1; c <= 30 && !seen; c++) begin
            @(negedge clk);
            if (c == 1 && !hold)
                bus.req_valid = 1'b0;
            if (bus.S)
                smask[c] = 1'b1;
            if (bus.R)
                rmask[c] = 1'b1;
            if (bus.S && bus.R)
                both = 1'b1;
            if (bus.done || bus.err) begin
                seen  = 1'b1;
                lat   = c;
                o_err = bus.err;
                o_rdy = bus.req_ready;
                o_q   = bus.state_q;
                o_kn  = bus.state_known;
            end
        end
        check({tag, ":response_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            e = sb.pop_front();
            check({tag, ":kind_err"}, 32'(o_err), 32'(e.is_err));
            check({tag, ":latency"}, 32'(lat),
                  32'(e.is_err ? LAT_TO : LAT_OK));
            check({tag, ":state_q"}, 32'(o_q), 32'(e.q));
            check({tag, ":state_known"}, 32'(o_kn), 32'(model_known));
            check({tag, ":ready_in_resp"}, 32'(o_rdy), 32'd1);
        end
        check({tag, ":s_mask"}, smask, set ? PMASK : 32'd0);
        check({tag, ":r_mask"}, rmask, set ? 32'd0 : PMASK);
        check({tag, ":s_and_r"}, 32'(both), 32'd0);
        if (hold)
            bus.req_set = next_set;
    endtask

    initial begin
        bit spurious;
        bus.req_valid = 1'b0;
        bus.req_set   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst:S", 32'(bus.S), 32'd0);
        check("rst:R", 32'(bus.R), 32'd0);
        check("rst:ready", 32'(bus.req_ready), 32'd1);
        check("rst:done", 32'(bus.done), 32'd0);
        check("rst:err", 32'(bus.err), 32'd0);
        check("rst:state_q", 32'(bus.state_q), 32'd0);
        check("rst:known", 32'(bus.state_known), 32'd0);
        n_rst = 1'b1;
        @(negedge clk);
        check("post_rst:ready", 32'(bus.req_ready), 32'd1);
        check("post_rst:known", 32'(bus.state_known), 32'd0);

        // Set, then reset
        run_cmd("set", 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        run_cmd("reset", 1'b0, 1'b1, 1'b0, 1'b0);
        check("reset:Q", 32'(bus.Q), 32'd0);
        check("reset:Qbar", 32'(bus.Qbar), 32'd1);

        // Stuck latch readback 00 -> timeout
        @(negedge clk);
        stuck = 1'b1;
        run_cmd("stuck", 1'b1, 1'b0, 1'b0, 1'b0);
        stuck = 1'b0;
        @(negedge clk);
        check("stuck:after_done", 32'(bus.done), 32'd0);

        // Back-to-back with req_valid held through the first command
        @(negedge clk);
        run_cmd("b2b_set", 1'b1, 1'b1, 1'b1, 1'b0);
        run_cmd("b2b_rst", 1'b0, 1'b1, 1'b0, 1'b0);
        check("b2b:sb_empty", 32'(sb.size()), 32'd0);

        // Reset asserted during cycle 2 of a set pulse
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_set   = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("midrst:S_before", 32'(bus.S), 32'd1);
        #1 n_rst = 1'b0;
        #1;
        check("midrst:S", 32'(bus.S), 32'd0);
        check("midrst:R", 32'(bus.R), 32'd0);
        check("midrst:ready", 32'(bus.req_ready), 32'd1);
        check("midrst:known", 32'(bus.state_known), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        model_q     = 1'b0;
        model_known = 1'b0;
        spurious = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.done || bus.err || bus.S || bus.R)
                spurious = 1'b1;
        end
        check("midrst:no_activity", 32'(spurious), 32'd0);
        check("midrst:state_q", 32'(bus.state_q), 32'(model_q));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
